// File: rtl/regex_instr_mem_responder.sv
// Instruction store for the regex CPU: program-load write port plus a three-state fetch responder.
// Optional last-hit shortcut: define REGEX_MEM_LAST_HIT_EN to skip the storage read on a repeat fetch.
module regex_instr_mem_responder #(
  parameter int MEMORY_WIDTH      = 20,
  parameter int MEMORY_ADDR_WIDTH = 11
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         memory_valid,
  input  logic [MEMORY_ADDR_WIDTH-1:0] memory_addr,
  output logic                         memory_ready,
  output logic [MEMORY_WIDTH-1:0]      memory_data,
  input  logic                         load_valid,
  input  logic [MEMORY_ADDR_WIDTH-1:0] load_addr,
  input  logic [MEMORY_WIDTH-1:0]      load_data,
  output logic                         load_ready
);

  localparam int DEPTH = 2 ** MEMORY_ADDR_WIDTH;

  // state | meaning
  // IDLE  | accept a fetch (priority) or a load
  // READ  | storage word available, register it onto memory_data
  // RESP  | one-cycle memory_ready strobe
  typedef enum logic [1:0] {IDLE, READ, RESP} state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [MEMORY_WIDTH-1:0] r_mem [DEPTH];
  logic [MEMORY_WIDTH-1:0] r_rd_word;
  logic [MEMORY_WIDTH-1:0] r_data;
  logic                    w_hit;
  logic                    w_rd_en;
  logic                    w_data_en;
  logic                    w_wr_en;

`ifdef REGEX_MEM_LAST_HIT_EN
  logic [MEMORY_ADDR_WIDTH-1:0] r_addr;
  logic [MEMORY_ADDR_WIDTH-1:0] r_tag_addr;
  logic                         r_tag_vld;

  // Tag follows the word currently held on memory_data; a load to that address makes it stale.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tag_vld <= 1'b0;
    end else begin
      if (w_rd_en) r_addr <= memory_addr;
      if (w_data_en) begin
        r_tag_addr <= r_addr;
        r_tag_vld  <= 1'b1;
      end else if (w_wr_en && (load_addr == r_tag_addr)) begin
        r_tag_vld  <= 1'b0;
      end
    end
  end

  assign w_hit = r_tag_vld && (memory_addr == r_tag_addr);
`else
  assign w_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_data  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_data_en) r_data <= r_rd_word;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_rd_en     = 1'b0;
    w_data_en   = 1'b0;
    case (r_state)
      IDLE: begin
        if (memory_valid) begin
          if (w_hit) begin
            w_state_nxt = RESP;
          end else begin
            w_rd_en     = 1'b1;
            w_state_nxt = READ;
          end
        end
      end
      READ: begin
        w_data_en   = 1'b1;
        w_state_nxt = RESP;
      end
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Storage is never reset; the program survives rst.
  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[load_addr] <= load_data;
    if (w_rd_en) r_rd_word <= r_mem[memory_addr];
  end

  assign load_ready   = (r_state == IDLE) && !memory_valid;
  assign w_wr_en      = load_valid && load_ready;
  assign memory_ready = (r_state == RESP) && !rst;
  assign memory_data  = r_data;

endmodule

// File: tb/tb_regex_instr_mem_responder.sv
// Scoreboard bench for regex_instr_mem_responder: driver pushes predicted responses, negedge monitor checks them.
// Latency predictions honour REGEX_MEM_LAST_HIT_EN when the bench is built with it.
module tb_regex_instr_mem_responder;

  localparam int W  = 20;
  localparam int AW = 11;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          memory_valid = 1'b0;
  logic [AW-1:0] memory_addr = '0;
  logic          memory_ready;
  logic [W-1:0]  memory_data;
  logic          load_valid = 1'b0;
  logic [AW-1:0] load_addr = '0;
  logic [W-1:0]  load_data = '0;
  logic          load_ready;

  regex_instr_mem_responder #(.MEMORY_WIDTH(W), .MEMORY_ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .memory_valid(memory_valid), .memory_addr(memory_addr),
    .memory_ready(memory_ready), .memory_data(memory_data),
    .load_valid(load_valid), .load_addr(load_addr),
    .load_data(load_data), .load_ready(load_ready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [W-1:0] d;
    int           c;
  } exp_t;

  exp_t          sb[$];
  exp_t          mon_e;
  logic [W-1:0]  mem_m [2**AW];
  logic [AW-1:0] loaded[$];
  logic [AW-1:0] tag_m = '0;
  bit            tag_vld_m = 1'b0;
  int            next_idle = 0;
  int            pending_exp = 0;
  logic [W-1:0]  hold_exp = '0;
  bit            prev_ready = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every strobe must match the head of the scoreboard in data and cycle.
  always @(negedge clk) begin
    if (cyc > 0) begin
      if (sb.size() > 0 && sb[0].c < cyc) begin
        checks++;
        errors++;
        $display("FAIL missing_strobe: no response seen, expected at cycle %0d (now %0d)", sb[0].c, cyc);
        void'(sb.pop_front());
      end
      if (memory_ready) begin
        chk("double_strobe", 32'(prev_ready), 32'd0);
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_strobe: memory_ready=1 data %h with nothing outstanding (cycle %0d)", memory_data, cyc);
        end else begin
          mon_e = sb.pop_front();
          chk("resp_data", 32'(memory_data), 32'(mon_e.d));
          chk("resp_cycle", 32'(cyc), 32'(mon_e.c));
          hold_exp = mon_e.d;
        end
      end else begin
        chk("data_hold", 32'(memory_data), 32'(hold_exp));
      end
      prev_ready = memory_ready;
    end
  end

  always @(posedge clk) if (rst) hold_exp = '0;

  // Caller is at negedge+1: predicts the sampling edge and the response cycle from the rules.
  task automatic start_fetch(input logic [AW-1:0] a);
    int   se;
    bit   hit;
    exp_t e;
    memory_valid = 1'b1;
    memory_addr  = a;
    se  = (cyc + 1 > next_idle) ? cyc + 1 : next_idle;
    hit = 1'b0;
`ifdef REGEX_MEM_LAST_HIT_EN
    hit       = tag_vld_m && (tag_m == a);
    tag_m     = a;
    tag_vld_m = 1'b1;
`endif
    e.d = mem_m[a];
    e.c = hit ? se : se + 1;
    sb.push_back(e);
    pending_exp = e.c;
  endtask

  task automatic finish_fetch(input bit keep);
    while (cyc < pending_exp) @(negedge clk);
    #1;
    if (!keep) memory_valid = 1'b0;
    next_idle = pending_exp + 2;
  endtask

  task automatic fetch(input logic [AW-1:0] a, input bit keep);
    @(negedge clk); #1;
    start_fetch(a);
    finish_fetch(keep);
  endtask

  task automatic do_load(input logic [AW-1:0] a, input logic [W-1:0] d);
    bit rdy;
    @(negedge clk); #1;
    load_valid = 1'b1;
    load_addr  = a;
    load_data  = d;
    rdy = load_ready;
    chk("load_ready_idle", 32'(rdy), 32'd1);
    @(posedge clk);
    if (rdy) begin
      mem_m[a] = d;
      if (tag_vld_m && tag_m == a) tag_vld_m = 1'b0;
      loaded.push_back(a);
    end
    #1 load_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit            keep_prev;
    bit            keep;
    int            op;
    logic [AW-1:0] a;

    repeat (3) @(negedge clk);
    chk("reset_ready", 32'(memory_ready), 32'd0);
    chk("reset_data", 32'(memory_data), 32'd0);
    chk("reset_load_ready", 32'(load_ready), 32'd1);
    #1 rst = 1'b0;

    do_load(11'd245, 20'h1A5C3);
    do_load(11'd246, 20'h0F00F);
    fetch(11'd245, 1'b0);
    fetch(11'd245, 1'b1);
    fetch(11'd246, 1'b0);

    // Fetch and load raised together: fetch wins, load stalls until the response is done.
    @(negedge clk); #1;
    load_valid = 1'b1;
    load_addr  = 11'd300;
    load_data  = 20'h00001;
    start_fetch(11'd245);
    while (cyc < pending_exp) begin
      @(negedge clk);
      chk("load_stall", 32'(load_ready), 32'd0);
    end
    #1 memory_valid = 1'b0;
    next_idle = pending_exp + 2;
    @(negedge clk);
    chk("load_after_fetch", 32'(load_ready), 32'd1);
    @(posedge clk);
    mem_m[300] = 20'h00001;
    loaded.push_back(11'd300);
    #1 load_valid = 1'b0;
    fetch(11'd300, 1'b0);

    // Reset during READ aborts the fetch without a strobe.
    @(negedge clk); #1;
    memory_valid = 1'b1;
    memory_addr  = 11'd246;
    @(negedge clk); #1;
    rst = 1'b1;
    memory_valid = 1'b0;
    @(negedge clk);
    chk("abort_ready", 32'(memory_ready), 32'd0);
    chk("abort_data", 32'(memory_data), 32'd0);
    #1 rst = 1'b0;
    tag_vld_m = 1'b0;
    next_idle = 0;
    fetch(11'd246, 1'b0);

`ifdef REGEX_MEM_LAST_HIT_EN
    fetch(11'd245, 1'b0);
    fetch(11'd245, 1'b0);
    do_load(11'd245, 20'h00ABC);
    fetch(11'd245, 1'b0);
`endif

    do_load(11'd2047, 20'hFFFFF);
    do_load(11'd0, 20'h00010);
    fetch(11'd2047, 1'b1);
    fetch(11'd0, 1'b0);

    keep_prev = 1'b0;
    for (int i = 0; i < 80; i++) begin
      op = keep_prev ? 1 : int'($urandom_range(0, 2));
      if (op == 0) begin
        a = AW'(240 + $urandom_range(0, 15));
        do_load(a, W'($urandom));
        keep_prev = 1'b0;
      end else begin
        a    = loaded[$urandom_range(0, loaded.size() - 1)];
        keep = 1'($urandom_range(0, 1));
        fetch(a, keep);
        keep_prev = keep;
      end
      if (!keep_prev) repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    @(negedge clk); #1;
    memory_valid = 1'b0;

    repeat (6) @(negedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
